home_inventory_sample_framer: RTL and testbench

// - Upstream sample source for the event detector: takes the ADC capture word stream (one

---
 rtl/home_inventory_pkg.sv | 18 +
 rtl/home_inventory_ts_counter.sv | 41 ++++
 rtl/home_inventory_sample_framer.sv | 142 ++++++++++++++
 tb/tb_home_inventory_sample_framer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/home_inventory_pkg.sv
// Shared definitions for the home-inventory sampling path: channel count,
// framer state encoding and the saturating counter helper.
package home_inventory_pkg;

  localparam int NCH = 8;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_COLLECT  = 2'd2
  } framer_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/home_inventory_ts_counter.sv
// Free-running 32-bit timestamp with a TS_DIV prescaler. The counter skips 0
// on wrap so that downstream logic can keep using 0 as "no timestamp yet".
module home_inventory_ts_counter #(
  parameter int          TS_DIV  = 1,
  parameter logic [31:0] TS_INIT = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ts_o
);

  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   ts_q, ts_d;
  logic          tick;

  // Prescaler and zero-skipping next timestamp.
  always_comb begin
    tick  = (pre_q == PW'(TS_DIV - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
    ts_d  = ts_q;
    if (tick) begin
      ts_d = (ts_q == 32'hFFFF_FFFF) ? 32'd1 : ts_q + 32'd1;
    end
  end

  // Register prescaler and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ts_q  <= TS_INIT;
    end else begin
      pre_q <= pre_d;
      ts_q  <= ts_d;
    end
  end

  assign ts_o = ts_q;

endmodule

// File: rtl/home_inventory_sample_framer.sv
// Assembles 8-channel frames from the ADC capture word stream, stamps each
// frame with the timestamp seen when its ch0 word was accepted, and presents
// the frame with a one-cycle sample_valid pulse.
// Input handshake: a word transfers on a cycle where in_valid && in_ready;
// in_ready depends only on the FSM state, and there is no output backpressure.
module home_inventory_sample_framer
  import home_inventory_pkg::*;
#(
  parameter int          DW      = 32,
  parameter int          TS_DIV  = 1,
  // Timestamp value after reset; must be non-zero (1 in normal use).
  parameter logic [31:0] TS_INIT = 32'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_ch,
  input  logic [DW-1:0] in_data,
  output logic          sample_valid,
  output logic [31:0]   ts_now,
  output logic [DW-1:0] sample_ch0,
  output logic [DW-1:0] sample_ch1,
  output logic [DW-1:0] sample_ch2,
  output logic [DW-1:0] sample_ch3,
  output logic [DW-1:0] sample_ch4,
  output logic [DW-1:0] sample_ch5,
  output logic [DW-1:0] sample_ch6,
  output logic [DW-1:0] sample_ch7,
  output logic [31:0]   ts_counter,
  output logic [31:0]   frame_count,
  output logic [31:0]   drop_count,
  output logic [1:0]    framer_state
);

  framer_state_e state_q;
  logic [2:0]    exp_q;
  logic [31:0]   ts_pend_q;
  logic [DW-1:0] buf_q [NCH];
  logic [DW-1:0] out_q [NCH];
  logic          sv_q;
  logic [31:0]   ts_now_q;
  logic [31:0]   fc_q;
  logic [31:0]   dc_q;
  logic [31:0]   ts_cnt;
  logic          accept;
  logic          last_word;

  home_inventory_ts_counter #(
    .TS_DIV  (TS_DIV),
    .TS_INIT (TS_INIT)
  ) u_ts (
    .clk   (clk),
    .rst_n (rst_n),
    .ts_o  (ts_cnt)
  );

  assign in_ready  = (state_q != ST_DISABLED);
  assign accept    = in_valid && in_ready;
  assign last_word = (exp_q == 3'(NCH - 1));

  // Framer FSM, assembly buffer and output registers. Completion loads the
  // outputs on the same edge that accepts ch7, so the assembly buffer is free
  // for the next frame's ch0 one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DISABLED;
      exp_q     <= '0;
      ts_pend_q <= '0;
      sv_q      <= 1'b0;
      ts_now_q  <= '0;
      fc_q      <= '0;
      dc_q      <= '0;
      for (int k = 0; k < NCH; k++) begin
        buf_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      sv_q <= 1'b0;
      if (!frame_en) begin
        // Abandon any partial frame; a word accepted now is discarded with it.
        if (state_q == ST_COLLECT) dc_q <= sat_inc32(dc_q);
        state_q <= ST_DISABLED;
      end else begin
        unique case (state_q)
          ST_DISABLED: state_q <= ST_SYNC;
          ST_SYNC: begin
            if (accept && in_ch == 3'd0) begin
              buf_q[0]  <= in_data;
              ts_pend_q <= ts_cnt;
              exp_q     <= 3'd1;
              state_q   <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (accept) begin
              if (in_ch == exp_q) begin
                buf_q[exp_q] <= in_data;
                exp_q        <= exp_q + 3'd1;
                if (last_word) begin
                  for (int k = 0; k < NCH - 1; k++) out_q[k] <= buf_q[k];
                  out_q[NCH-1] <= in_data;
                  ts_now_q     <= ts_pend_q;
                  sv_q         <= 1'b1;
                  fc_q         <= sat_inc32(fc_q);
                  state_q      <= ST_SYNC;
                end
              end else begin
                dc_q <= sat_inc32(dc_q);
                if (in_ch == 3'd0) begin
                  buf_q[0]  <= in_data;
                  ts_pend_q <= ts_cnt;
                  exp_q     <= 3'd1;
                end else begin
                  state_q <= ST_SYNC;
                end
              end
            end
          end
          default: state_q <= ST_DISABLED;
        endcase
      end
    end
  end

  assign sample_valid = sv_q;
  assign ts_now       = ts_now_q;
  assign sample_ch0   = out_q[0];
  assign sample_ch1   = out_q[1];
  assign sample_ch2   = out_q[2];
  assign sample_ch3   = out_q[3];
  assign sample_ch4   = out_q[4];
  assign sample_ch5   = out_q[5];
  assign sample_ch6   = out_q[6];
  assign sample_ch7   = out_q[7];
  assign ts_counter   = ts_cnt;
  assign frame_count  = fc_q;
  assign drop_count   = dc_q;
  assign framer_state = state_q;

endmodule

// File: tb/tb_home_inventory_sample_framer.sv
// Bench for home_inventory_sample_framer. Three instances share one input
// stream: the normal configuration, one starting just below the timestamp
// wrap, and one with a divide-by-3 timestamp prescaler.
module tb_home_inventory_sample_framer;

  localparam logic [31:0] W_INIT = 32'hFFFF_FFFE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        frame_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_ch = '0;
  logic [31:0] in_data = '0;

  // main instance
  logic        in_ready, sample_valid;
  logic [31:0] ts_now, ts_counter, frame_count, drop_count;
  logic [31:0] ch [8];
  logic [1:0]  framer_state;
  // wrap instance
  logic        w_ready, w_sv;
  logic [31:0] w_ts_now, w_ts, w_fc, w_dc;
  logic [31:0] w_ch [8];
  logic [1:0]  w_st;
  // divided instance
  logic        d_ready, d_sv;
  logic [31:0] d_ts_now, d_ts, d_fc, d_dc;
  logic [31:0] d_ch [8];
  logic [1:0]  d_st;

  home_inventory_sample_framer dut (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .sample_valid(sample_valid), .ts_now(ts_now),
    .sample_ch0(ch[0]), .sample_ch1(ch[1]), .sample_ch2(ch[2]), .sample_ch3(ch[3]),
    .sample_ch4(ch[4]), .sample_ch5(ch[5]), .sample_ch6(ch[6]), .sample_ch7(ch[7]),
    .ts_counter(ts_counter), .frame_count(frame_count), .drop_count(drop_count),
    .framer_state(framer_state)
  );

  home_inventory_sample_framer #(.TS_INIT(W_INIT)) dut_w (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .in_valid(in_valid),
    .in_ready(w_ready), .in_ch(in_ch), .in_data(in_data),
    .sample_valid(w_sv), .ts_now(w_ts_now),
    .sample_ch0(w_ch[0]), .sample_ch1(w_ch[1]), .sample_ch2(w_ch[2]), .sample_ch3(w_ch[3]),
    .sample_ch4(w_ch[4]), .sample_ch5(w_ch[5]), .sample_ch6(w_ch[6]), .sample_ch7(w_ch[7]),
    .ts_counter(w_ts), .frame_count(w_fc), .drop_count(w_dc), .framer_state(w_st)
  );

  home_inventory_sample_framer #(.TS_DIV(3)) dut_d (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .in_valid(in_valid),
    .in_ready(d_ready), .in_ch(in_ch), .in_data(in_data),
    .sample_valid(d_sv), .ts_now(d_ts_now),
    .sample_ch0(d_ch[0]), .sample_ch1(d_ch[1]), .sample_ch2(d_ch[2]), .sample_ch3(d_ch[3]),
    .sample_ch4(d_ch[4]), .sample_ch5(d_ch[5]), .sample_ch6(d_ch[6]), .sample_ch7(d_ch[7]),
    .ts_counter(d_ts), .frame_count(d_fc), .drop_count(d_dc), .framer_state(d_st)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Timestamp after k counted edges: values cycle through 1..2^32-1.
  function automatic logic [31:0] tsf(input logic [31:0] init, input int div, input longint k);
    longint m;
    longint p;
    m = k / div;
    p = 64'h0000_0000_FFFF_FFFF;
    return 32'((((longint'(init) - 1) + m) % p) + 1);
  endfunction

  // ---------------- behavioural model ----------------
  // A partial frame is the list of accepted words so far; the next wanted
  // channel is simply its length.
  typedef struct {
    logic [31:0] d;
    int          k;
  } wrd_t;

  wrd_t        p[$];
  logic        m_on = 1'b0;
  int          m_k = 0;
  logic        m_sv = 1'b0;
  logic        m_have = 1'b0;
  int          m_ts_k = 0;
  logic [31:0] m_out [8];
  logic [31:0] m_fc = '0;
  logic [31:0] m_dc = '0;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) m_out[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        p.delete();
        m_on = 1'b0; m_k = 0; m_sv = 1'b0; m_have = 1'b0; m_ts_k = 0;
        m_fc = '0; m_dc = '0;
        for (int i = 0; i < 8; i++) m_out[i] = '0;
      end else begin
        m_sv = 1'b0;
        if (!frame_en) begin
          if (p.size() > 0) m_dc = sat(m_dc);
          p.delete();
        end else if (m_on && in_valid) begin
          if (p.size() == 0) begin
            if (in_ch == 3'd0) p.push_back('{d: in_data, k: m_k});
          end else if (int'(in_ch) == p.size()) begin
            p.push_back('{d: in_data, k: m_k});
            if (p.size() == 8) begin
              for (int i = 0; i < 8; i++) m_out[i] = p[i].d;
              m_ts_k = p[0].k;
              m_have = 1'b1;
              m_sv = 1'b1;
              m_fc = sat(m_fc);
              p.delete();
            end
          end else begin
            m_dc = sat(m_dc);
            p.delete();
            if (in_ch == 3'd0) p.push_back('{d: in_data, k: m_k});
          end
        end
        m_on = frame_en;
        m_k++;
      end
    end
  end

  // ---------------- compare process (every negedge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", {31'd0, in_ready}, {31'd0, m_on});
      check("state", {30'd0, framer_state}, !m_on ? 32'd0 : (p.size() == 0 ? 32'd1 : 32'd2));
      check("sample_valid", {31'd0, sample_valid}, {31'd0, m_sv});
      check("ts_counter", ts_counter, tsf(32'd1, 1, m_k));
      check("ts_now", ts_now, m_have ? tsf(32'd1, 1, m_ts_k) : 32'd0);
      for (int i = 0; i < 8; i++) check($sformatf("sample_ch%0d", i), ch[i], m_out[i]);
      check("frame_count", frame_count, m_fc);
      check("drop_count", drop_count, m_dc);
      check("w_sample_valid", {31'd0, w_sv}, {31'd0, m_sv});
      check("w_ts_counter", w_ts, tsf(W_INIT, 1, m_k));
      check("w_ts_now", w_ts_now, m_have ? tsf(W_INIT, 1, m_ts_k) : 32'd0);
      check("d_sample_valid", {31'd0, d_sv}, {31'd0, m_sv});
      check("d_ts_counter", d_ts, tsf(32'd1, 3, m_k));
      check("d_ts_now", d_ts_now, m_have ? tsf(32'd1, 3, m_ts_k) : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic word(input logic [2:0] c, input logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = c;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] base);
    for (int i = 0; i < 8; i++) word(3'(i), base + 32'(i));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst ts_counter", ts_counter, 32'd1);
    check("rst w ts_counter", w_ts, 32'hFFFF_FFFE);
    check("rst frame_count", frame_count, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);

    // Release reset and enable together on a falling edge.
    rst_n = 1'b1;
    frame_en = 1'b1;
    @(negedge clk);
    check("lit ts after 1 edge", ts_counter, 32'd2);
    check("lit w ts wrap-1", w_ts, 32'hFFFF_FFFF);
    check("lit state sync", {30'd0, framer_state}, 32'd1);
    @(negedge clk);
    check("lit w ts wrapped", w_ts, 32'd1);
    // Clean frame: ch0 presented here, accepted with main ts=3, wrap ts=1, div3 ts=1.
    in_valid = 1'b1; in_ch = 3'd0; in_data = 32'h10;
    for (int i = 1; i < 8; i++) word(3'(i), 32'h10 + 32'(i));
    idle(1);
    check("lit clean sample_valid", {31'd0, sample_valid}, 32'd1);
    check("lit clean ts_now", ts_now, 32'd3);
    check("lit clean w ts_now", w_ts_now, 32'd1);
    check("lit clean d ts_now", d_ts_now, 32'd1);
    check("lit clean ch0", ch[0], 32'h10);
    check("lit clean ch7", ch[7], 32'h17);
    check("lit clean frame_count", frame_count, 32'd1);
    idle(1);
    check("lit pulse one cycle", {31'd0, sample_valid}, 32'd0);

    // Sequence error ch0,ch1,ch3, then a clean frame.
    word(3'd0, 32'hA0); word(3'd1, 32'hA1); word(3'd3, 32'hA3);
    idle(1);
    check("lit seq drop_count", drop_count, 32'd1);
    check("lit seq state", {30'd0, framer_state}, 32'd1);
    frame(32'h20);
    idle(1);
    check("lit seq frame ch3", ch[3], 32'h23);
    check("lit seq frame_count", frame_count, 32'd2);

    // Restart on ch0 mid-frame.
    word(3'd0, 32'h30); word(3'd1, 32'h31);
    frame(32'h40);
    idle(1);
    check("lit restart drop_count", drop_count, 32'd2);
    check("lit restart ch0", ch[0], 32'h40);
    check("lit restart frame_count", frame_count, 32'd3);
    idle(2);

    // Back-to-back frames.
    frame(32'h60);
    frame(32'h70);
    idle(1);
    check("lit b2b frame_count", frame_count, 32'd5);
    check("lit b2b ch5", ch[5], 32'h75);

    // Disable mid-frame after ch4; a ch5 word in the disabling cycle is discarded.
    for (int i = 0; i < 5; i++) word(3'(i), 32'h80 + 32'(i));
    @(negedge clk);
    in_valid = 1'b1; in_ch = 3'd5; in_data = 32'h85;
    frame_en = 1'b0;
    idle(1);
    check("lit dis in_ready", {31'd0, in_ready}, 32'd0);
    check("lit dis drop_count", drop_count, 32'd3);
    idle(4);
    frame_en = 1'b1;
    idle(1);
    frame(32'h50);
    idle(1);
    check("lit reen sample_valid", {31'd0, sample_valid}, 32'd1);
    check("lit reen ch6", ch[6], 32'h56);
    check("lit reen frame_count", frame_count, 32'd6);

    // Async reset after ch5.
    for (int i = 0; i < 6; i++) word(3'(i), 32'h90 + 32'(i));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("lit arst sample_valid", {31'd0, sample_valid}, 32'd0);
    check("lit arst ts_counter", ts_counter, 32'd1);
    check("lit arst ts_now", ts_now, 32'd0);
    check("lit arst ch0", ch[0], 32'd0);
    check("lit arst frame_count", frame_count, 32'd0);
    check("lit arst drop_count", drop_count, 32'd0);
    check("lit arst state", {30'd0, framer_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    check("lit arst no frame", frame_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
